// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU control codes, BIST polynomials and
// the BIST sequencer state encoding.
package mips_pkg;

    // ALU control codes, shared with the ALU control unit.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Operand LFSR (Galois, right shift) and signature MISR polynomials.
    localparam logic [31:0] BIST_LFSR_MASK = 32'h80200003;
    localparam logic [31:0] BIST_MISR_POLY = 32'h04C11DB7;

    // Ops per operand pair; the op index runs 0..BIST_LAST_OP.
    localparam logic [2:0] BIST_LAST_OP = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCapture,
        StDone
    } bist_state_e;

    // Map an op index to its ALU control code; unused indices fall back to AND.
    function automatic logic [3:0] bist_op_ctrl(input logic [2:0] op);
        logic [3:0] ctrl;
        case (op)
            3'd0:    ctrl = ALU_AND;
            3'd1:    ctrl = ALU_OR;
            3'd2:    ctrl = ALU_ADD;
            3'd3:    ctrl = ALU_SUB;
            3'd4:    ctrl = ALU_SLT;
            3'd5:    ctrl = ALU_NOR;
            default: ctrl = ALU_AND;
        endcase
        return ctrl;
    endfunction

    // One Galois LFSR step.
    function automatic logic [31:0] bist_lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? BIST_LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 32-bit multiple-input signature register compressing ALU Output/Zero
// responses. load_i restarts from SEED; en_i folds in one response.
module bist_misr
    import mips_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hFFFFFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [31:0] data_i,
    input  logic        zero_i,
    output logic [31:0] sig_o
);

    logic [31:0] misr_q;
    logic [31:0] misr_d;

    // Next signature: load has priority over a compression step.
    always_comb begin
        misr_d = misr_q;
        if (load_i) begin
            misr_d = SEED;
        end else if (en_i) begin
            misr_d = {misr_q[30:0], 1'b0}
                   ^ (misr_q[31] ? BIST_MISR_POLY : 32'h0)
                   ^ data_i
                   ^ {31'b0, zero_i};
        end
    end

    // Signature register; reset returns to the seed so no partial result survives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misr_q <= SEED;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign sig_o = misr_q;

endmodule

// File: rtl/ula_bist.sv
// Built-in self-test sequencer for the datapath ALU (ULA). Drives LFSR
// operand pairs through every ALU op, compresses responses into a MISR and
// compares the final signature against a golden value.
module ula_bist
    import mips_pkg::*;
#(
    parameter int unsigned NUM_VECTORS  = 64,
    parameter logic [31:0] LFSR_SEED    = 32'hACE12345,
    parameter logic [31:0] MISR_SEED    = 32'hFFFFFFFF,
    parameter logic [31:0] EXPECTED_SIG = 32'h00000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [31:0] Signature,
    output logic [31:0] AluData1,
    output logic [31:0] AluData2,
    output logic [3:0]  AluControl,
    input  logic [31:0] AluOutput,
    input  logic        AluZero
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h00000001 : LFSR_SEED;
    localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

    bist_state_e state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [15:0] vec_q, vec_d;
    logic [2:0]  op_q, op_d;
    logic        misr_load;
    logic        misr_en;
    logic        active;

    // Next-state logic: DRIVE settles the ALU inputs, CAPTURE samples the response.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        vec_d     = vec_q;
        op_d      = op_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    state_d   = StDrive;
                    lfsr_d    = SEED_EFF;
                    vec_d     = 16'h0;
                    op_d      = 3'd0;
                    misr_load = 1'b1;
                end
            end
            StDrive: begin
                state_d = StCapture;
            end
            StCapture: begin
                misr_en = 1'b1;
                if (op_q != BIST_LAST_OP) begin
                    op_d    = op_q + 3'd1;
                    state_d = StDrive;
                end else if (vec_q != LAST_VEC) begin
                    op_d    = 3'd0;
                    vec_d   = vec_q + 16'd1;
                    lfsr_d  = bist_lfsr_step(lfsr_q);
                    state_d = StDrive;
                end else begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state and counters.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            lfsr_q  <= 32'h0;
            vec_q   <= 16'h0;
            op_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            vec_q   <= vec_d;
            op_q    <= op_d;
        end
    end

    bist_misr #(
        .SEED (MISR_SEED)
    ) u_misr (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .load_i (misr_load),
        .en_i   (misr_en),
        .data_i (AluOutput),
        .zero_i (AluZero),
        .sig_o  (Signature)
    );

    // Status and ALU drive; the ALU inputs are zero whenever no op is in flight.
    always_comb begin
        active     = (state_q == StDrive) || (state_q == StCapture);
        Busy       = active;
        Done       = (state_q == StDone);
        Pass       = Done && (Signature == EXPECTED_SIG);
        AluData1   = active ? lfsr_q : 32'h0;
        AluData2   = active ? {lfsr_q[15:0], lfsr_q[31:16]} : 32'h0;
        AluControl = active ? bist_op_ctrl(op_q) : 4'b0000;
    end

endmodule

// File: tb/tb_ula_bist.sv
// Self-checking bench for ula_bist: per-cycle sequence table on a 1-vector
// instance, tied-response signature, golden vs stuck-at ALU on 64 vectors,
// Start-while-busy, rerun and asynchronous reset mid-run.
module tb_ula_bist;

    // Reference ALU: returns {zero, output}.
    function automatic logic [32:0] ula_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] ctl);
        logic [31:0] r;
        case (ctl)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            default: r = 32'h0;
        endcase
        return {(r == 32'h0), r};
    endfunction

    function automatic logic [3:0] ctl_of(input int o);
        logic [3:0] c;
        case (o)
            0:       c = 4'b0000;
            1:       c = 4'b0001;
            2:       c = 4'b0010;
            3:       c = 4'b0110;
            4:       c = 4'b0111;
            default: c = 4'b1100;
        endcase
        return c;
    endfunction

    // Expected final signature of a run against a fault-free ALU (n <= 64).
    function automatic logic [31:0] model_sig(input int n, input logic [31:0] lseed,
                                              input logic [31:0] mseed);
        logic [31:0] l;
        logic [31:0] m;
        logic [32:0] r;
        int k;
        l = (lseed == 32'h0) ? 32'h1 : lseed;
        m = mseed;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (k < n) begin
                    for (int o = 0; o < 6; o++) begin
                        r = ula_model(l, {l[15:0], l[31:16]}, ctl_of(o));
                        m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0)
                          ^ r[31:0] ^ {31'b0, r[32]};
                    end
                    l = (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
                end
                k++;
            end
        end
        return m;
    endfunction

    localparam logic [31:0] GOLDEN64 = model_sig(64, 32'hACE12345, 32'hFFFFFFFF);

    logic Clock = 1'b0;
    logic Reset;
    logic start_a;
    logic start_x;

    always #5 Clock = ~Clock;

    // Instance A: single vector, seed 1, fault-free ALU.
    logic        busy_a, done_a, pass_a, zero_a;
    logic [31:0] sig_a, d1_a, d2_a, out_a;
    logic [3:0]  ctl_a;
    assign {zero_a, out_a} = ula_model(d1_a, d2_a, ctl_a);

    ula_bist #(
        .NUM_VECTORS (1),
        .LFSR_SEED   (32'h00000001)
    ) dut_a (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (start_a),
        .Busy       (busy_a),
        .Done       (done_a),
        .Pass       (pass_a),
        .Signature  (sig_a),
        .AluData1   (d1_a),
        .AluData2   (d2_a),
        .AluControl (ctl_a),
        .AluOutput  (out_a),
        .AluZero    (zero_a)
    );

    // Instance B: zero MISR seed, ALU response tied to Output=0, Zero=1.
    logic        busy_b, done_b, pass_b;
    logic [31:0] sig_b, d1_b, d2_b;
    logic [3:0]  ctl_b;

    ula_bist #(
        .NUM_VECTORS  (1),
        .MISR_SEED    (32'h00000000),
        .EXPECTED_SIG (32'h0000003F)
    ) dut_b (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (start_x),
        .Busy       (busy_b),
        .Done       (done_b),
        .Pass       (pass_b),
        .Signature  (sig_b),
        .AluData1   (d1_b),
        .AluData2   (d2_b),
        .AluControl (ctl_b),
        .AluOutput  (32'h0),
        .AluZero    (1'b1)
    );

    // Instance C: 64 vectors, ALU output bit 4 stuck at 0.
    logic        busy_c, done_c, pass_c, zero_c;
    logic [31:0] sig_c, d1_c, d2_c, raw_c;
    logic [3:0]  ctl_c;
    assign {zero_c, raw_c} = ula_model(d1_c, d2_c, ctl_c);

    ula_bist #(
        .EXPECTED_SIG (GOLDEN64)
    ) dut_c (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (start_x),
        .Busy       (busy_c),
        .Done       (done_c),
        .Pass       (pass_c),
        .Signature  (sig_c),
        .AluData1   (d1_c),
        .AluData2   (d2_c),
        .AluControl (ctl_c),
        .AluOutput  (raw_c & 32'hFFFFFFEF),
        .AluZero    (zero_c)
    );

    // Instance D: 64 vectors, fault-free ALU.
    logic        busy_d, done_d, pass_d, zero_d;
    logic [31:0] sig_d, d1_d, d2_d, out_d;
    logic [3:0]  ctl_d;
    assign {zero_d, out_d} = ula_model(d1_d, d2_d, ctl_d);

    ula_bist #(
        .EXPECTED_SIG (GOLDEN64)
    ) dut_d (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (start_x),
        .Busy       (busy_d),
        .Done       (done_d),
        .Pass       (pass_d),
        .Signature  (sig_d),
        .AluData1   (d1_d),
        .AluData2   (d2_d),
        .AluControl (ctl_d),
        .AluOutput  (out_d),
        .AluZero    (zero_d)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  ctl;
        logic        busy;
        logic        done;
        logic [31:0] d1;
        logic [31:0] d2;
    } vec_t;

    vec_t tbl [13];

    // Start instance A and compare 13 cycles against the table; Start is
    // re-pulsed after samples p1 and p2 to show it is ignored while busy.
    task automatic run_table(input string tag, input int p1, input int p2);
        start_a = 1'b1;
        @(negedge Clock);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("%s_ctl[%0d]", tag, i), {28'b0, ctl_a}, {28'b0, tbl[i].ctl});
            check($sformatf("%s_busy[%0d]", tag, i), {31'b0, busy_a}, {31'b0, tbl[i].busy});
            check($sformatf("%s_done[%0d]", tag, i), {31'b0, done_a}, {31'b0, tbl[i].done});
            check($sformatf("%s_d1[%0d]", tag, i), d1_a, tbl[i].d1);
            check($sformatf("%s_d2[%0d]", tag, i), d2_a, tbl[i].d2);
            start_a = (i == p1) || (i == p2);
            @(negedge Clock);
        end
        start_a = 1'b0;
    endtask

    logic [3:0] ctl_seq [6];
    int busy_cnt;
    int guard;
    logic [31:0] sig_a_model;

    initial begin
        ctl_seq[0] = 4'b0000;
        ctl_seq[1] = 4'b0001;
        ctl_seq[2] = 4'b0010;
        ctl_seq[3] = 4'b0110;
        ctl_seq[4] = 4'b0111;
        ctl_seq[5] = 4'b1100;
        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{ctl: ctl_seq[i / 2], busy: 1'b1, done: 1'b0,
                       d1: 32'h00000001, d2: 32'h00010000};
        end
        tbl[12] = '{ctl: 4'b0000, busy: 1'b0, done: 1'b1, d1: 32'h0, d2: 32'h0};
        sig_a_model = model_sig(1, 32'h00000001, 32'hFFFFFFFF);

        // Reset while idle.
        Reset = 1'b1;
        start_a = 1'b0;
        start_x = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_busy", {31'b0, busy_a}, 32'h0);
        check("rst_done", {31'b0, done_a}, 32'h0);
        check("rst_pass", {31'b0, pass_a}, 32'h0);
        check("rst_sig", sig_a, 32'hFFFFFFFF);
        check("rst_d1", d1_a, 32'h0);
        check("rst_d2", d2_a, 32'h0);
        check("rst_ctl", {28'b0, ctl_a}, 32'h0);
        check("rst_sig_b", sig_b, 32'h0);
        check("rst_d1_b", d1_b | d2_b | {28'b0, ctl_b}, 32'h0);

        // Instances B, C, D run together; count D's busy cycles.
        start_x = 1'b1;
        @(negedge Clock);
        start_x = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (busy_d && guard < 2000) begin
            busy_cnt++;
            guard++;
            @(negedge Clock);
        end
        check("d_busy_len", busy_cnt, 32'd768);
        check("d_done", {31'b0, done_d}, 32'h1);
        check("d_sig_golden", sig_d, GOLDEN64);
        check("d_pass", {31'b0, pass_d}, 32'h1);
        check("c_done", {31'b0, done_c}, 32'h1);
        check("c_pass", {31'b0, pass_c}, 32'h0);
        check("c_sig_differs", {31'b0, sig_c != GOLDEN64}, 32'h1);
        check("b_busy", {31'b0, busy_b}, 32'h0);
        check("b_done", {31'b0, done_b}, 32'h1);
        check("b_sig", sig_b, 32'h0000003F);
        check("b_pass", {31'b0, pass_b}, 32'h1);

        // Per-cycle sequence, then a run with Start pulsed while busy.
        run_table("seq", -1, -1);
        check("seq_sig", sig_a, sig_a_model);
        check("seq_pass", {31'b0, pass_a}, {31'b0, sig_a_model == 32'h0});
        repeat (2) @(negedge Clock);
        check("done_hold", {31'b0, done_a}, 32'h1);
        check("sig_hold", sig_a, sig_a_model);
        run_table("rerun", 2, 6);
        check("rerun_sig", sig_a, sig_a_model);

        // Asynchronous reset at cycle 5 of a run, checked between clock edges.
        start_a = 1'b1;
        @(negedge Clock);
        start_a = 1'b0;
        repeat (4) @(negedge Clock);
        check("mid_busy_pre", {31'b0, busy_a}, 32'h1);
        #2 Reset = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy_a}, 32'h0);
        check("arst_done", {31'b0, done_a}, 32'h0);
        check("arst_sig", sig_a, 32'hFFFFFFFF);
        check("arst_d1", d1_a, 32'h0);
        check("arst_d2", d2_a, 32'h0);
        check("arst_ctl", {28'b0, ctl_a}, 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        start_a = 1'b1;
        @(negedge Clock);
        start_a = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (busy_a && guard < 100) begin
            busy_cnt++;
            guard++;
            @(negedge Clock);
        end
        check("post_rst_busy_len", busy_cnt, 32'd12);
        check("post_rst_done", {31'b0, done_a}, 32'h1);
        check("post_rst_sig", sig_a, sig_a_model);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
